// File: rtl/cmem_pkg.sv
// Shared types for the state-memory streaming block: FSM encoding and
// the amplitude width helper (one complex amplitude = real + imaginary).
package cmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Width of one complex amplitude given the width of one component.
  function automatic int amp_w(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/cmem_stream_out_if.sv
// Output beat stream of cmem_stream_out: valid/ready handshake carrying
// one amplitude, its basis-state index and a last-beat marker.
interface cmem_stream_out_if
  import cmem_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 32
);

  localparam int AMP_W  = amp_w(DATA_W);
  localparam int ADDR_W = $clog2(N);

  logic              m_valid;
  logic              m_ready;
  logic [AMP_W-1:0]  m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_index,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/cmem_stream_out.sv
// Streams the whole state vector out of a combinational-read state memory,
// one amplitude per accepted beat, indices 0..N-1 in ascending order.
// The read address advances only when the output register is free, so the
// beat register never overruns under back-pressure.
module cmem_stream_out
  import cmem_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = 32,
  localparam int AMP_W  = amp_w(DATA_W),
  localparam int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [AMP_W-1:0]  mem_data,
  cmem_stream_out_if.master m_if,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  state_t            state_r;
  state_t            next_state_s;

  logic [ADDR_W-1:0] mem_addr_r;
  logic              reads_done_r;   // all N reads issued; mem_addr parks at N-1
  logic              m_valid_r;
  logic [AMP_W-1:0]  m_data_r;
  logic [ADDR_W-1:0] m_index_r;
  logic              m_last_r;
  logic              busy_r;
  logic              done_r;

  logic              hs_s;
  logic              load_s;
  logic              final_hs_s;

  // Handshake/load qualifiers and next-state selection.
  always_comb begin
    next_state_s = state_r;
    hs_s         = m_valid_r && m_if.m_ready;
    load_s       = 1'b0;
    final_hs_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_STREAM;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        load_s     = (!m_valid_r || m_if.m_ready) && !reads_done_r;
        final_hs_s = reads_done_r && hs_s && m_last_r;
        if (final_hs_s) begin
          next_state_s = ST_FINISH;
        end else begin
          next_state_s = ST_STREAM;
        end
      end
      ST_FINISH: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Read address, output beat register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_r   <= '0;
      reads_done_r <= 1'b0;
      m_valid_r    <= 1'b0;
      m_data_r     <= '0;
      m_index_r    <= '0;
      m_last_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      busy_r <= (next_state_s == ST_STREAM);
      done_r <= (next_state_s == ST_FINISH);
      if ((state_r == ST_IDLE) && start) begin
        mem_addr_r   <= '0;
        reads_done_r <= 1'b0;
      end else if (load_s) begin
        m_valid_r <= 1'b1;
        m_data_r  <= mem_data;
        m_index_r <= mem_addr_r;
        m_last_r  <= (mem_addr_r == LAST_ADDR);
        if (mem_addr_r == LAST_ADDR) begin
          reads_done_r <= 1'b1;          // hold at N-1, never wrap
        end else begin
          mem_addr_r <= mem_addr_r + ADDR_W'(1);
        end
      end else if (hs_s) begin
        m_valid_r <= 1'b0;               // last beat taken, nothing left to load
      end
    end
  end

  assign mem_addr     = mem_addr_r;
  assign m_if.m_valid = m_valid_r;
  assign m_if.m_data  = m_data_r;
  assign m_if.m_index = m_index_r;
  assign m_if.m_last  = m_last_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule
